// File: rtl/instr_fetch_cache.sv
// Direct-mapped, one-word-per-entry instruction cache between the fetch port and instruction memory.
// Hits are combinational; misses and idle-cycle hint prefetches use a single outstanding memory read.
module instr_fetch_cache #(
  parameter int ENTRIES  = 16,
  parameter int CNT_W    = 16,
  parameter int LEN_WORD = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init,
  input  logic                fetch_order,
  input  logic [LEN_WORD-1:0] fetch_pc,
  output logic                fetch_done,
  output logic [LEN_WORD-1:0] fetch_instr,
  input  logic [LEN_WORD-1:0] fetch_hint,
  output logic                mem_req,
  output logic [LEN_WORD-1:0] mem_addr,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [LEN_WORD-1:0] mem_rdata,
  output logic [CNT_W-1:0]    perf_hit,
  output logic [CNT_W-1:0]    perf_miss
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = LEN_WORD - 2 - IDX_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t              state_r;
  logic                drop_r;
  logic [LEN_WORD-1:0] last_pref_r;
  logic [ENTRIES-1:0]  valid_r;
  logic [TAG_W-1:0]    tag_r  [ENTRIES];
  logic [LEN_WORD-1:0] data_r [ENTRIES];

  logic [IDX_W-1:0] pc_idx_s, hint_idx_s, fill_idx_s;
  logic [TAG_W-1:0] pc_tag_s, hint_tag_s, fill_tag_s;
  logic             hit_s, hint_hit_s, fill_en_s;
  logic             unused_s;

  assign pc_idx_s   = fetch_pc[2 +: IDX_W];
  assign pc_tag_s   = fetch_pc[LEN_WORD-1 : 2+IDX_W];
  assign hint_idx_s = fetch_hint[2 +: IDX_W];
  assign hint_tag_s = fetch_hint[LEN_WORD-1 : 2+IDX_W];
  assign fill_idx_s = mem_addr[2 +: IDX_W];
  assign fill_tag_s = mem_addr[LEN_WORD-1 : 2+IDX_W];
  assign unused_s   = ^{fetch_pc[1:0], fetch_hint[1:0], mem_addr[1:0]};

  assign hit_s       = fetch_order & valid_r[pc_idx_s] & (tag_r[pc_idx_s] == pc_tag_s) & ~init;
  assign hint_hit_s  = valid_r[hint_idx_s] & (tag_r[hint_idx_s] == hint_tag_s);
  // A fill that coincides with init or follows one is discarded.
  assign fill_en_s   = (state_r == ST_WAIT) & mem_rvalid & ~drop_r & ~init;
  assign fetch_done  = hit_s;
  assign fetch_instr = data_r[pc_idx_s];

  // Valid bits: cleared by reset or init, set by an accepted fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
    end else if (init) begin
      valid_r <= '0;
    end else if (fill_en_s) begin
      valid_r[fill_idx_s] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag and data storage, written only on an accepted fill.
  always_ff @(posedge clk) begin
    if (fill_en_s) begin
      tag_r[fill_idx_s]  <= fill_tag_s;
      data_r[fill_idx_s] <= mem_rdata;
    end
  end

  // Fill controller, memory request outputs and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      drop_r      <= 1'b0;
      last_pref_r <= '0;
      perf_hit    <= '0;
      perf_miss   <= '0;
    end else begin
      if (hit_s && (perf_hit != {CNT_W{1'b1}})) begin
        perf_hit <= perf_hit + CNT_ONE;
      end
      case (state_r)
        ST_IDLE: begin
          if (!init) begin
            if (fetch_order && !hit_s) begin
              state_r  <= ST_REQ;
              mem_req  <= 1'b1;
              mem_addr <= {fetch_pc[LEN_WORD-1:2], 2'b00};
              if (perf_miss != {CNT_W{1'b1}}) begin
                perf_miss <= perf_miss + CNT_ONE;
              end
            end else if (!hint_hit_s && (fetch_hint != last_pref_r)) begin
              state_r     <= ST_REQ;
              mem_req     <= 1'b1;
              mem_addr    <= {fetch_hint[LEN_WORD-1:2], 2'b00};
              last_pref_r <= fetch_hint;
            end
          end
        end
        ST_REQ: begin
          // The bus request is never withdrawn; init only marks the result for discard.
          if (mem_gnt) begin
            state_r <= ST_WAIT;
            mem_req <= 1'b0;
          end
          if (init) begin
            drop_r <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            state_r <= ST_IDLE;
            drop_r  <= 1'b0;
          end else if (init) begin
            drop_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          mem_req <= 1'b0;
          drop_r  <= 1'b0;
        end
      endcase
      if (init) begin
        last_pref_r <= '0;
      end
    end
  end

endmodule
